// File: rtl/stream_mux_8x1_rr.sv
// 8-to-1 valid/ready stream multiplexer with round-robin arbitration, optional
// packet locking and a registered output stage (1-cycle latency).
module stream_mux_8x1_rr #(
  parameter int unsigned DATA_W   = 8,
  parameter bit          LOCK_PKT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_valid,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic [7:0]          in_last,
  output logic [7:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [2:0]          out_sel,
  input  logic                out_ready
);

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          cur_q, cur_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [2:0]          out_sel_q, out_sel_d;

  logic [2:0]          grant_idx;
  logic [2:0]          scan_idx;
  logic                found;
  logic                any_valid;
  logic                load;
  logic [2:0]          sel_idx;
  logic                accept;
  logic                beat_last;

  // Round-robin search: first valid channel starting at ptr_q, wrapping mod 8.
  always_comb begin
    grant_idx = ptr_q;
    scan_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!found && in_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Ready generation, next-state and output-register update.
  always_comb begin
    any_valid   = |in_valid;
    load        = !out_valid_q || out_ready;
    sel_idx     = (state_q == StHold) ? cur_q : grant_idx;

    // in_ready is gated by rst_n so nothing looks accepted while reset is held.
    in_ready = '0;
    if (rst_n && load) begin
      if (state_q == StHold) begin
        in_ready[cur_q] = 1'b1;
      end else if (any_valid) begin
        in_ready[grant_idx] = 1'b1;
      end
    end
    accept    = |(in_ready & in_valid);
    beat_last = in_last[sel_idx];

    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (accept) begin
      if (state_q == StArb) begin
        ptr_d = grant_idx + 3'd1;
        if (LOCK_PKT && !beat_last) begin
          state_d = StHold;
          cur_d   = grant_idx;
        end
      end else if (beat_last) begin
        state_d = StArb;
      end
      out_valid_d = 1'b1;
      out_data_d  = in_data[sel_idx*DATA_W +: DATA_W];
      out_last_d  = LOCK_PKT ? beat_last : 1'b1;
      out_sel_d   = sel_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArb;
      ptr_q       <= '0;
      cur_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_8x1_rr.sv
// Scoreboard bench for stream_mux_8x1_rr: a reference arbiter predicts in_ready
// and each accepted beat, which is queued and compared when it reaches the output.
module tb_stream_mux_8x1_rr;

  localparam int DW = 8;

  typedef struct packed {
    logic [2:0]    sel;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_valid;
  logic [8*DW-1:0] in_data;
  logic [7:0]    in_last;
  logic [7:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [2:0]    out_sel;
  logic          out_ready;

  int n_checks = 0;
  int n_errors = 0;

  beat_t sb[$];
  int    m_ptr  = 0;
  bit    m_hold = 1'b0;
  int    m_cur  = 0;
  bit    m_ov   = 1'b0;

  stream_mux_8x1_rr #(
    .DATA_W  (DW),
    .LOCK_PKT(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_hold = 1'b0;
    m_cur  = 0;
    m_ov   = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: check at the falling edge, advance the model, return 1 time unit
  // after the rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    logic [7:0] er;
    bit         ld;
    bit         acc;
    int         g;
    int         s;
    beat_t      b;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      check_eq("rst_in_ready", 32'(in_ready), 32'h0);
      check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    end else begin
      ld = !m_ov || out_ready;
      g  = -1;
      for (int k = 0; k < 8; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      end
      er = '0;
      if (ld) begin
        if (m_hold) er[m_cur] = 1'b1;
        else if (g >= 0) er[g] = 1'b1;
      end
      check_eq("in_ready", 32'(in_ready), 32'(er));
      check_eq("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov && sb.size() > 0) begin
        check_eq("out_sel", 32'(out_sel), 32'(sb[0].sel));
        check_eq("out_data", 32'(out_data), 32'(sb[0].data));
        check_eq("out_last", 32'(out_last), 32'(sb[0].last));
        if (out_ready) void'(sb.pop_front());
      end
      s   = m_hold ? m_cur : g;
      acc = ld && (s >= 0) && in_valid[s];
      if (acc) begin
        b.sel  = 3'(s);
        b.data = in_data[s*DW +: DW];
        b.last = in_last[s];
        sb.push_back(b);
        if (!m_hold) begin
          m_ptr = (g + 1) % 8;
          if (!in_last[g]) begin
            m_hold = 1'b1;
            m_cur  = g;
          end
        end else if (in_last[m_cur]) begin
          m_hold = 1'b0;
        end
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every channel requesting.
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    in_last   = 8'hFF;
    in_data   = {$urandom, $urandom};
    out_ready = 1'b1;
    step();
    check_eq("rst_out_sel", 32'(out_sel), 32'h0);
    step();
    rst_n = 1'b1;

    // All channels valid, single-beat packets: 0..7,0 with no gaps.
    for (int i = 0; i < 9; i++) begin
      in_data = {$urandom, $urandom};
      step();
      if (i == 0) check_eq("first_grant", 32'(out_sel), 32'h0);
    end

    // Move pointer to 3 via ch2, then ch5 and ch2 compete: ch5 wins first.
    in_valid = 8'b0000_0100;
    step();
    in_valid = 8'b0010_0100;
    in_data  = {$urandom, $urandom};
    step();
    check_eq("rr_ch5_first", 32'(out_sel), 32'd5);
    in_valid = 8'b0000_0100;
    in_data  = {$urandom, $urandom};
    step();
    check_eq("rr_ch2_next", 32'(out_sel), 32'd2);
    in_valid = 8'h00;
    step();
    step();

    // Start a packet on ch1, then reset asynchronously while locked.
    in_valid = 8'b0000_0010;
    in_last  = 8'h00;
    step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'h0);
    check_eq("async_rst_ready", 32'(in_ready), 32'h0);
    model_reset();
    in_valid = 8'b0001_1000;
    in_last  = 8'h00;
    step();
    rst_n = 1'b1;

    // ch3 sends 3 beats while ch4 stays valid; ch4 must wait for the lock.
    in_data = {$urandom, $urandom};
    step();
    check_eq("post_rst_grant", 32'(out_sel), 32'd3);
    check_eq("lock_rdy4", 32'(in_ready[4]), 32'h0);
    in_data = {$urandom, $urandom};
    step();
    check_eq("lock_beat2", 32'(out_sel), 32'd3);
    in_last = 8'b0000_1000;
    in_data = {$urandom, $urandom};
    step();
    check_eq("lock_beat3", 32'(out_sel), 32'd3);
    in_valid = 8'b0001_0000;
    in_last  = 8'hFF;
    in_data  = {$urandom, $urandom};
    step();
    check_eq("after_lock_ch4", 32'(out_sel), 32'd4);

    // Backpressure: hold out_ready low for 4 cycles, then resume.
    in_valid = 8'hFF;
    in_data  = {$urandom, $urandom};
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom};
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom, $urandom};
      step();
    end
    in_valid = 8'h00;
    step();
    step();

    // Random traffic with random backpressure and packet boundaries.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 8'($urandom);
      in_last   = 8'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain: finish any locked packet, then empty the output.
    out_ready = 1'b1;
    in_valid  = 8'hFF;
    in_last   = 8'hFF;
    step();
    in_valid = 8'h00;
    step();
    step();
    step();
    check_eq("drain_empty", 32'(sb.size()), 32'h0);
    check_eq("drain_valid", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
